// File: rtl/key_debounce_pkg.sv
// key_debounce shared constants and helpers.
// Default qualification length and counter width function.
package key_debounce_pkg;

  // 20 ms at a 12 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 240000;

  // Counter width holding 0..cycles-1 (never narrower than 1 bit).
  function automatic int CNT_W(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// Single-bit key debouncer: synchronizer, qualification counter,
// debounced level and registered press pulse.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  localparam int W = CNT_W(CYCLES);
  localparam logic [W-1:0] CNT_MAX = W'(CYCLES - 1);

  logic [1:0]   sync_q, sync_d;
  logic         stable_q, stable_d;
  logic         stable_dly_q, stable_dly_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_q, pulse_d;
  logic         s;

  assign s = sync_q[1];

  // Next-state: sync shift, qualification count, press detect.
  always_comb begin
    sync_d       = {sync_q[0], key_i};
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    stable_dly_d = stable_q;
    pulse_d      = stable_dly_q & ~stable_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; released (1) is the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/key_debounce.sv
// N-channel active-low key debouncer.
// One press pulse per accepted 1->0 debounced transition.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N               = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .key_i  (key[i]),
      .pulse_o(key_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce, N=2, DEBOUNCE_CYCLES=4.
// Expected pulse cycles are queued at stimulus time.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] key_pulse;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  key_debounce #(
    .N(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .key_pulse(key_pulse)
  );

  // Scoreboard: pop expected pulse cycles, flag unexpected pulses.
  always @(negedge clk) begin
    logic e0, e1;
    e0 = (q0.size() > 0) && (q0[0] == cyc);
    e1 = (q1.size() > 0) && (q1[0] == cyc);
    if (e0) void'(q0.pop_front());
    if (e1) void'(q1.pop_front());
    if (e0 || key_pulse[0] !== 1'b0) begin
      n_cmp++;
      if (key_pulse[0] !== e0) begin
        n_bad++;
        $display("FAIL pulse0 cyc=%0d got=%b exp=%b", cyc, key_pulse[0], e0);
      end
    end
    if (e1 || key_pulse[1] !== 1'b0) begin
      n_cmp++;
      if (key_pulse[1] !== e1) begin
        n_bad++;
        $display("FAIL pulse1 cyc=%0d got=%b exp=%b", cyc, key_pulse[1], e1);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 2'b11;
    wait_n(3);
    n_cmp++;
    if (key_pulse !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_val got=%b exp=00", key_pulse);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_n(1);
      n_cmp++;
      if (key_pulse !== 2'b00) begin
        n_bad++;
        $display("FAIL idle got=%b exp=00 i=%0d", key_pulse, i);
      end
    end
  endtask

  task automatic test_press();
    key[0] = 1'b0;
    q0.push_back(cyc + 7);
    wait_n(20);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL press_missed left=%0d exp=0", q0.size());
    end
    key[0] = 1'b1;
    wait_n(10);
  endtask

  task automatic test_bounce();
    key[0] = 1'b0; wait_n(1);
    key[0] = 1'b1; wait_n(1);
    key[0] = 1'b0; wait_n(1);
    key[0] = 1'b1; wait_n(1);
    key[0] = 1'b0;
    q0.push_back(cyc + 7);
    wait_n(20);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL bounce_missed left=%0d exp=0", q0.size());
    end
    key[0] = 1'b1;
    wait_n(10);
  endtask

  task automatic test_short();
    key[0] = 1'b0;
    wait_n(3);
    key[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_n(1);
      n_cmp++;
      if (key_pulse[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL short_press got=%b exp=0 i=%0d", key_pulse[0], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    key[0] = 1'b0;
    q0.push_back(cyc + 7);
    wait_n(15);
    key[0] = 1'b1;
    wait_n(6);
    key[0] = 1'b0;
    q0.push_back(cyc + 7);
    wait_n(15);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL repress_missed left=%0d exp=0", q0.size());
    end
    key[0] = 1'b1;
    wait_n(2);
    key[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wait_n(1);
      n_cmp++;
      if (key_pulse[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL short_release got=%b exp=0 i=%0d", key_pulse[0], i);
      end
    end
    key[0] = 1'b1;
    wait_n(10);
  endtask

  task automatic test_reset_mid();
    int t;
    key[0] = 1'b0;
    q0.push_back(cyc + 7);
    wait_n(3);
    rst = 1'b0;
    q0.delete();
    #1;
    n_cmp++;
    if (key_pulse !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid got=%b exp=00", key_pulse);
    end
    wait_n(2);
    rst = 1'b1;
    q0.push_back(cyc + 7);
    wait_n(15);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_repulse left=%0d exp=0", q0.size());
    end
    key[0] = 1'b1;
    wait_n(10);
    key[0] = 1'b0;
    t = cyc + 7;
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (key_pulse[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL pulse_before_rst got=%b exp=1", key_pulse[0]);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (key_pulse !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_async_drop got=%b exp=00", key_pulse);
    end
    wait_n(1);
    rst = 1'b1;
    q0.push_back(cyc + 7);
    wait_n(15);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL rst_hi_repulse left=%0d exp=0", q0.size());
    end
    key[0] = 1'b1;
    wait_n(10);
  endtask

  task automatic test_channels();
    key[1] = 1'b0;
    q1.push_back(cyc + 7);
    wait_n(15);
    key[1] = 1'b1;
    wait_n(10);
    key = 2'b00;
    q0.push_back(cyc + 7);
    q1.push_back(cyc + 7);
    wait_n(15);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL chan_missed left=%0d/%0d exp=0/0",
               q0.size(), q1.size());
    end
    key = 2'b11;
    wait_n(10);
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_short();
    test_back_to_back();
    test_reset_mid();
    test_channels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
